uart_cmd_parser: RTL and testbench

- Frame-level controller downstream of the UART byte receiver; consumes byte strobes (rx_msg/rx_parity/rx_complete) on the 3.125 MHz domain.
- Assembles fixed 6-byte command frames, validates parity marker, checksum and terminator, and enforces an inter-byte timeout.
- Presents decoded opcode + 16-bit argument to the robot control logic through a valid/ready handshake; reports errors as one-cycle coded pulses.

---
 rtl/uart_cmd_parser.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Frame-level command parser downstream of a UART byte receiver.
//               Assembles 6-byte frames  SOF, OPCODE, ARG_HI, ARG_LO, CHK, EOF
//               (CHK = OPCODE ^ ARG_HI ^ ARG_LO). Validates the parity marker,
//               checksum, terminator and the inter-byte timeout. Hands decoded
//               commands to the consumer over a valid/ready handshake and
//               reports errors as one-cycle coded pulses.
// Ports       : clk_3125    - 3.125 MHz system clock
//               reset       - asynchronous active-high reset
//               rx_msg      - received byte (8'h3F marks a parity failure)
//               rx_parity   - received parity bit, valid with rx_complete
//               rx_complete - one-cycle byte strobe
//               cmd_ready   - consumer accepts when high together with cmd_valid
//               cmd_valid   - command held valid until accepted
//               cmd_opcode  - decoded opcode
//               cmd_arg     - decoded argument {ARG_HI, ARG_LO}
//               err_pulse   - one-cycle error strobe
//               err_code    - 1 parity, 2 checksum, 3 terminator, 4 timeout,
//                             5 overrun; holds the last code
//               busy        - high while a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0]  SOF_BYTE       = 8'h23,
    parameter logic [7:0]  EOF_BYTE       = 8'h0A,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_3125,
    input  logic        reset,
    input  logic [7:0]  rx_msg,
    input  logic        rx_parity,
    input  logic        rx_complete,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [15:0] cmd_arg,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPC  = 3'd1,
        S_AHI  = 3'd2,
        S_ALO  = 3'd3,
        S_CHK  = 3'd4,
        S_EOF  = 3'd5
    } state_t;

    localparam logic [2:0]  c_ERR_PARITY = 3'd1;
    localparam logic [2:0]  c_ERR_CHKSUM = 3'd2;
    localparam logic [2:0]  c_ERR_TERM   = 3'd3;
    localparam logic [2:0]  c_ERR_TMO    = 3'd4;
    localparam logic [2:0]  c_ERR_OVRUN  = 3'd5;
    localparam logic [7:0]  c_PAR_MARK   = 8'h3F;
    // The counter holds the number of idle cycles since the last strobe.
    // Firing when it is about to reach TIMEOUT_CYCLES puts the error edge
    // exactly TIMEOUT_CYCLES edges after the strobe edge.
    localparam logic [15:0] c_TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_tmo;
    logic [7:0]  r_opc;
    logic [7:0]  r_ahi;
    logic [7:0]  r_alo;
    logic [7:0]  r_chk;

    logic w_par_err;
    logic w_accept;

    assign w_par_err = (rx_msg == c_PAR_MARK) && rx_parity;
    assign w_accept  = cmd_valid && cmd_ready;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tmo      <= 16'd0;
            r_opc      <= 8'd0;
            r_ahi      <= 8'd0;
            r_alo      <= 8'd0;
            r_chk      <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_opcode <= 8'd0;
            cmd_arg    <= 16'd0;
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            err_pulse <= 1'b0;

            // A same-cycle load below overrides this clear.
            if (w_accept) begin
                cmd_valid <= 1'b0;
            end

            if ((r_state == S_IDLE) || rx_complete) begin
                r_tmo <= 16'd0;
            end else begin
                r_tmo <= r_tmo + 16'd1;
            end

            if (rx_complete) begin
                if (w_par_err && (r_state != S_IDLE)) begin
                    err_pulse <= 1'b1;
                    err_code  <= c_ERR_PARITY;
                    r_state   <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            // Parity-marked bytes and noise are dropped here.
                            if (rx_msg == SOF_BYTE) begin
                                r_state <= S_OPC;
                            end
                        end
                        S_OPC: begin
                            r_opc   <= rx_msg;
                            r_chk   <= rx_msg;
                            r_state <= S_AHI;
                        end
                        S_AHI: begin
                            r_ahi   <= rx_msg;
                            r_chk   <= r_chk ^ rx_msg;
                            r_state <= S_ALO;
                        end
                        S_ALO: begin
                            r_alo   <= rx_msg;
                            r_chk   <= r_chk ^ rx_msg;
                            r_state <= S_CHK;
                        end
                        S_CHK: begin
                            if (rx_msg != r_chk) begin
                                err_pulse <= 1'b1;
                                err_code  <= c_ERR_CHKSUM;
                                r_state   <= S_IDLE;
                            end else begin
                                r_state <= S_EOF;
                            end
                        end
                        S_EOF: begin
                            r_state <= S_IDLE;
                            if (rx_msg != EOF_BYTE) begin
                                err_pulse <= 1'b1;
                                err_code  <= c_ERR_TERM;
                            end else if (!cmd_valid || cmd_ready) begin
                                cmd_opcode <= r_opc;
                                cmd_arg    <= {r_ahi, r_alo};
                                cmd_valid  <= 1'b1;
                            end else begin
                                // Consumer still holds the previous command:
                                // keep it and drop the new frame.
                                err_pulse <= 1'b1;
                                err_code  <= c_ERR_OVRUN;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end else if ((r_state != S_IDLE) && (r_tmo == c_TMO_LAST)) begin
                err_pulse <= 1'b1;
                err_code  <= c_ERR_TMO;
                r_state   <= S_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Directed self-checking bench for uart_cmd_parser. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    logic        clk_3125;
    logic        reset;
    logic [7:0]  rx_msg;
    logic        rx_parity;
    logic        rx_complete;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_arg;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    uart_cmd_parser #(
        .SOF_BYTE       (8'h23),
        .EOF_BYTE       (8'h0A),
        .TIMEOUT_CYCLES (4096)
    ) u_dut (
        .clk_3125    (clk_3125),
        .reset       (reset),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_opcode  (cmd_opcode),
        .cmd_arg     (cmd_arg),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .busy        (busy)
    );

    initial clk_3125 = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; strobes one byte at the next rising edge and
    // returns on the following falling edge, where that edge's results show.
    task automatic send(input logic [7:0] b, input logic p);
        rx_msg      = b;
        rx_parity   = p;
        rx_complete = 1'b1;
        @(negedge clk_3125);
        rx_complete = 1'b0;
        rx_msg      = 8'h00;
        rx_parity   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [7:0] ahi,
                              input logic [7:0] alo, input logic [7:0] chk,
                              input logic [7:0] eof);
        send(8'h23, 1'b0);
        send(opc, 1'b0);
        send(ahi, 1'b0);
        send(alo, 1'b0);
        send(chk, 1'b0);
        send(eof, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_msg      = 8'h00;
        rx_parity   = 1'b0;
        rx_complete = 1'b0;
        cmd_ready   = 1'b1;
        repeat (3) @(negedge clk_3125);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_code", {29'd0, err_code}, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        reset = 1'b0;
        @(negedge clk_3125);

        // Good frame, consumer ready.
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 8'h0A);
        check("t1_valid", {31'd0, cmd_valid}, 32'd1);
        check("t1_opcode", {24'd0, cmd_opcode}, 32'h01);
        check("t1_arg", {16'd0, cmd_arg}, 32'h1234);
        check("t1_no_err", {31'd0, err_pulse}, 32'd0);
        check("t1_err_code", {29'd0, err_code}, 32'd0);
        @(negedge clk_3125);
        check("t1_valid_cleared", {31'd0, cmd_valid}, 32'd0);

        // Checksum error, then recovery.
        send(8'h23, 1'b0);
        send(8'h01, 1'b0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        check("t2_busy_mid", {31'd0, busy}, 32'd1);
        send(8'h26, 1'b0);
        check("t2_pulse", {31'd0, err_pulse}, 32'd1);
        check("t2_code", {29'd0, err_code}, 32'd2);
        check("t2_busy", {31'd0, busy}, 32'd0);
        send(8'h0A, 1'b0);
        check("t2_valid", {31'd0, cmd_valid}, 32'd0);
        check("t2_pulse_gone", {31'd0, err_pulse}, 32'd0);
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h64, 8'h0A);
        check("t2_recover_valid", {31'd0, cmd_valid}, 32'd1);
        check("t2_recover_opc", {24'd0, cmd_opcode}, 32'h02);
        check("t2_recover_arg", {16'd0, cmd_arg}, 32'hABCD);
        @(negedge clk_3125);

        // Parity marker mid-frame and in IDLE.
        send(8'h23, 1'b0);
        send(8'h05, 1'b0);
        send(8'h3F, 1'b1);
        check("t3_pulse", {31'd0, err_pulse}, 32'd1);
        check("t3_code", {29'd0, err_code}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        send(8'h3F, 1'b1);
        check("t3_idle_no_pulse", {31'd0, err_pulse}, 32'd0);
        check("t3_idle_busy", {31'd0, busy}, 32'd0);
        check("t3_idle_code_hold", {29'd0, err_code}, 32'd1);

        // Timeout expiry.
        send(8'h23, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        repeat (4095) @(negedge clk_3125);
        check("t4_before_expiry", {31'd0, err_pulse}, 32'd0);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk_3125);
        check("t4_pulse", {31'd0, err_pulse}, 32'd1);
        check("t4_code", {29'd0, err_code}, 32'd4);
        check("t4_busy", {31'd0, busy}, 32'd0);

        // Strobe on the expiry cycle wins.
        send(8'h23, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        repeat (4095) @(negedge clk_3125);
        send(8'h12, 1'b0);
        check("t4b_no_pulse", {31'd0, err_pulse}, 32'd0);
        check("t4b_busy", {31'd0, busy}, 32'd1);
        send(8'h10, 1'b0);
        send(8'h0A, 1'b0);
        check("t4b_valid", {31'd0, cmd_valid}, 32'd1);
        check("t4b_arg", {16'd0, cmd_arg}, 32'h0012);
        @(negedge clk_3125);

        // Overrun with consumer stalled.
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 8'h0A);
        check("t5_first_valid", {31'd0, cmd_valid}, 32'd1);
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h64, 8'h0A);
        check("t5_pulse", {31'd0, err_pulse}, 32'd1);
        check("t5_code", {29'd0, err_code}, 32'd5);
        check("t5_held_valid", {31'd0, cmd_valid}, 32'd1);
        check("t5_held_opc", {24'd0, cmd_opcode}, 32'h01);
        check("t5_held_arg", {16'd0, cmd_arg}, 32'h1234);
        cmd_ready = 1'b1;
        @(negedge clk_3125);
        check("t5_accept_clear", {31'd0, cmd_valid}, 32'd0);

        // Accept and load on the same edge.
        cmd_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 8'h0A);
        send(8'h23, 1'b0);
        send(8'h02, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        send(8'h64, 1'b0);
        cmd_ready = 1'b1;
        send(8'h0A, 1'b0);
        cmd_ready = 1'b0;
        check("t5b_valid", {31'd0, cmd_valid}, 32'd1);
        check("t5b_opc", {24'd0, cmd_opcode}, 32'h02);
        check("t5b_arg", {16'd0, cmd_arg}, 32'hABCD);
        check("t5b_no_pulse", {31'd0, err_pulse}, 32'd0);

        // Asynchronous reset mid-frame with a command pending.
        send(8'h23, 1'b0);
        send(8'h01, 1'b0);
        send(8'h12, 1'b0);
        #40;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("t6_rst_opc", {24'd0, cmd_opcode}, 32'd0);
        check("t6_rst_arg", {16'd0, cmd_arg}, 32'd0);
        check("t6_rst_code", {29'd0, err_code}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_3125);
        reset     = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk_3125);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 8'h0A);
        check("t6_valid", {31'd0, cmd_valid}, 32'd1);
        check("t6_opc", {24'd0, cmd_opcode}, 32'h01);
        check("t6_arg", {16'd0, cmd_arg}, 32'h1234);
        @(negedge clk_3125);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 8'h0B);
        check("t6_term_pulse", {31'd0, err_pulse}, 32'd1);
        check("t6_term_code", {29'd0, err_code}, 32'd3);
        check("t6_term_valid", {31'd0, cmd_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
